// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 iterations and a sign-fix cycle).
// MTHI/MTLO write in a single cycle. busy tells the pipeline to stall MFHI/MFLO.
module mul_div_unit (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;         // multiplicand magnitude (multiply)
  logic [31:0] b_q, b_d;         // divisor magnitude (divide)
  logic [63:0] acc_q, acc_d;     // product, or {remainder, quotient}
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        divz_q, divz_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_step, div_step;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Operand decode: magnitudes and sign flags of the incoming operands.
  always_comb begin
    op_signed = (op == 3'd0) || (op == 3'd2);
    a_neg     = op_signed && rs_val[31];
    b_neg     = op_signed && rt_val[31];
    a_mag     = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag     = b_neg ? (32'd0 - rt_val) : rt_val;
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
    mul_step = {mul_sum, acc_q[31:1]};
    div_rem  = acc_q[63:31];
    div_diff = {1'b0, div_rem} - {2'b00, b_q};
    // Borrow set means the shifted remainder is below the divisor: restore.
    if (div_diff[33]) begin
      div_step = {div_rem[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Sign correction of the finished result.
  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quot_fix = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    orig_a_d  = orig_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d  = op[1];
              a_d       = a_mag;
              b_d       = b_mag;
              acc_d     = {32'd0, (op[1] ? a_mag : b_mag)};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              divz_d    = op[1] && (rt_val == 32'd0);
              orig_a_d  = rs_val;
              cnt_d     = 6'd0;
              state_d   = StCalc;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (divz_q) begin
            hi_d = orig_a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      orig_a_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      orig_a_q  <= orig_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  mul_div_unit dut (
    .CLK    (CLK),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a MULT/DIV-class op and check latency, done pulse and result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    int busy_cnt;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0    = hi;
    lo0    = lo;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      if (i == 16) begin
        chk({tag, "_hi_hold"}, hi, hi0);
        chk({tag, "_lo_hold"}, lo, lo0);
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    tick();
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_seen;
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    abort  = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7byneg2");
    run_op(3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

    // MTHI then MTLO on consecutive cycles.
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op     = 3'd5;
    rs_val = 32'h9ABC_DEF0;
    tick();
    start  = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_keep", hi, 32'h1234_5678);
    chk("mtlo_done", {31'd0, done}, 32'd0);

    // MTHI requested while busy is ignored.
    start  = 1'b1;
    op     = 3'd1;
    rs_val = 32'd2;
    rt_val = 32'd3;
    tick();
    op     = 3'd4;
    rs_val = 32'hDEAD_BEEF;
    repeat (4) tick();
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("busy_mthi_hi", hi, 32'd0);
    chk("busy_mthi_lo", lo, 32'd6);

    // DIVU 50/7 aborted at E10.
    tick();
    start  = 1'b1;
    op     = 3'd3;
    rs_val = 32'd50;
    rt_val = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort10_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("abort10_no_done", 32'(done_seen), 32'd0);
    chk("abort10_hi", hi, 32'd0);
    chk("abort10_lo", lo, 32'd6);

    // DIVU 50/7 aborted at E33 (the FIX edge).
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("abort33_busy_pre", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort33_busy", {31'd0, busy}, 32'd0);
    chk("abort33_done", {31'd0, done}, 32'd0);
    chk("abort33_hi", hi, 32'd0);
    chk("abort33_lo", lo, 32'd6);
    tick();
    chk("abort33_done2", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'hAAAA_5555;
    tick();
    op     = 3'd0;
    rs_val = 32'd9;
    rt_val = 32'd9;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #4;
    reset = 1'b1;
    #1;
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_done", {31'd0, done}, 32'd0);
    chk("areset_hi", hi, 32'd0);
    chk("areset_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3x5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
